pipeline_sequencer: RTL and testbench

- Run-control sequencer for the 5-stage MIPS pipeline.
- Merges hazard-unit stall/flush requests with debug-unit run/step/stop commands.
- Produces the per-stage enable and flush strobes for PC, IF/ID, ID/EX and the EX/MEM/WB registers.
- Detects a HALT instruction in ID, drains in-flight instructions and reports completion and cycle count to the debug UART unit.

---
 rtl/pipeline_sequencer_pkg.sv | 16 +
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_sequencer.sv | 105 ++++++++++
 tb/tb_pipeline_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared run-control definitions: state encoding and drain default.
// The debug unit imports this so its o_state decode matches the sequencer.
package pipeline_sequencer_pkg;

   localparam int unsigned STATE_W          = 3;
   localparam int unsigned DRAIN_CYCLES_DEF = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      STEP   = 3'd2,
      DRAIN  = 3'd3,
      HALTED = 3'd4
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned NB = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [NB-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer: merges hazard requests with debug run/step/stop,
// drains the pipeline after HALT or stop, and counts executed cycles.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned NB_STATE     = STATE_W,
   parameter int unsigned NB_DRAIN     = 3,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned NB_CYCLE     = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start_run,
   input  logic                i_start_step,
   input  logic                i_stop,
   input  logic                i_halt_id,
   input  logic                i_hz_stall,
   input  logic                i_hz_flush,
   output logic                o_pc_en,
   output logic                o_ifid_en,
   output logic                o_ifid_flush,
   output logic                o_idex_flush,
   output logic                o_stage_en,
   output logic                o_busy,
   output logic                o_halted,
   output logic [NB_CYCLE-1:0] o_cycle_count,
   output logic [NB_STATE-1:0] o_state
);

   state_t              state;
   state_t              state_nxt;
   logic [NB_DRAIN-1:0] drain_cnt;
   logic                load_drain;
   logic                go_drain;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         drain_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load_drain)
            drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
         else if ((state == DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - 1'b1;
      end
   end

   // A HALT held off by a load-use stall is not yet committed; wait for the stall to clear.
   assign go_drain = i_stop | (i_halt_id & ~i_hz_stall);

   always_comb begin
      state_nxt    = state;
      load_drain   = 1'b0;
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;
      o_stage_en   = 1'b0;
      o_busy       = 1'b0;
      o_halted     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start_run)
               state_nxt = RUN;
            else if (i_start_step)
               state_nxt = STEP;
         end
         RUN, STEP: begin
            o_busy       = 1'b1;
            o_stage_en   = 1'b1;
            o_pc_en      = ~i_hz_stall & ~i_halt_id;
            o_ifid_en    = ~i_hz_stall;
            o_idex_flush = i_hz_stall;
            o_ifid_flush = (i_hz_flush | i_halt_id) & ~i_hz_stall;
            if (go_drain) begin
               state_nxt  = DRAIN;
               load_drain = 1'b1;
            end else if (state == STEP) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            o_busy       = 1'b1;
            o_stage_en   = 1'b1;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            if (drain_cnt == '0)
               state_nxt = HALTED;
         end
         HALTED: o_halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_state = NB_STATE'(state);

   sat_counter #(.NB(NB_CYCLE)) u_cycle_count (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (o_stage_en),
      .count (o_cycle_count)
   );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a reference model pushes expected
// per-cycle outputs into a scoreboard, popped and compared mid-cycle.
module tb_pipeline_sequencer;

   localparam int unsigned DRAIN_N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_run = 1'b0, start_step = 1'b0, stop = 1'b0;
   logic        halt_id = 1'b0, hz_stall = 1'b0, hz_flush = 1'b0;
   logic        pc_en, ifid_en, ifid_flush, idex_flush, stage_en, busy, halted;
   logic [31:0] cycle_count;
   logic [2:0]  state;

   always #5 clk = ~clk;

   pipeline_sequencer #(
      .NB_STATE     (3),
      .NB_DRAIN     (3),
      .DRAIN_CYCLES (DRAIN_N),
      .NB_CYCLE     (32)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start_run   (start_run),
      .i_start_step  (start_step),
      .i_stop        (stop),
      .i_halt_id     (halt_id),
      .i_hz_stall    (hz_stall),
      .i_hz_flush    (hz_flush),
      .o_pc_en       (pc_en),
      .o_ifid_en     (ifid_en),
      .o_ifid_flush  (ifid_flush),
      .o_idex_flush  (idex_flush),
      .o_stage_en    (stage_en),
      .o_busy        (busy),
      .o_halted      (halted),
      .o_cycle_count (cycle_count),
      .o_state       (state)
   );

   typedef struct packed {
      logic        pc_en, ifid_en, ifid_flush, idex_flush, stage_en, busy, halted;
      logic [2:0]  st;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          se_seen = 0;
   int          m_state = 0;
   int          m_left = 0;
   logic [31:0] m_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      case (m_state)
         1, 2: begin
            e.stage_en   = 1'b1;
            e.busy       = 1'b1;
            e.pc_en      = !hz_stall && !halt_id;
            e.ifid_en    = !hz_stall;
            e.idex_flush = hz_stall;
            e.ifid_flush = !hz_stall && (hz_flush || halt_id);
         end
         3: begin
            e.stage_en   = 1'b1;
            e.busy       = 1'b1;
            e.ifid_flush = 1'b1;
            e.idex_flush = 1'b1;
         end
         4: e.halted = 1'b1;
         default: ;
      endcase
      e.st  = 3'(m_state);
      e.cnt = m_cnt;
      return e;
   endfunction

   task automatic model_update(input exp_t e);
      if (e.stage_en && (m_cnt != 32'hFFFF_FFFF))
         m_cnt = m_cnt + 1;
      case (m_state)
         0: if (start_run) m_state = 1; else if (start_step) m_state = 2;
         1, 2: begin
            if (stop || (halt_id && !hz_stall)) begin
               m_state = 3;
               m_left  = DRAIN_N;
            end else if (m_state == 2) begin
               m_state = 0;
            end
         end
         3: if (m_left == 1) m_state = 4; else m_left = m_left - 1;
         default: ;
      endcase
   endtask

   task automatic drive(input logic run, input logic step, input logic stp,
                        input logic hlt, input logic stl, input logic fls);
      start_run  = run;
      start_step = step;
      stop       = stp;
      halt_id    = hlt;
      hz_stall   = stl;
      hz_flush   = fls;
      sb.push_back(model_out());
   endtask

   task automatic tick();
      exp_t e;
      e = '0;
      @(negedge clk);
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) e = sb.pop_front();
      check("pc_en", 32'(pc_en), 32'(e.pc_en));
      check("ifid_en", 32'(ifid_en), 32'(e.ifid_en));
      check("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
      check("idex_flush", 32'(idex_flush), 32'(e.idex_flush));
      check("stage_en", 32'(stage_en), 32'(e.stage_en));
      check("busy", 32'(busy), 32'(e.busy));
      check("halted", 32'(halted), 32'(e.halted));
      check("state", 32'(state), 32'(e.st));
      check("cycle_count", cycle_count, e.cnt);
      if (stage_en) se_seen++;
      @(posedge clk);
      model_update(e);
      #1;
      {start_run, start_step, stop, halt_id, hz_stall, hz_flush} = '0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   // Reset lands mid-cycle so outputs are checked before any clock edge.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_outputs", 32'({pc_en, ifid_en, ifid_flush, idex_flush, stage_en, busy, halted}), 0);
      check("rst_state", 32'(state), 0);
      check("rst_count", cycle_count, 0);
      m_state = 0;
      m_left  = 0;
      m_cnt   = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      apply_reset();

      // Free run, then stall+flush, flush alone, then HALT and drain.
      drive(1, 0, 0, 0, 0, 0); tick();
      cycles(10);
      check("run_state", 32'(state), 1);
      check("run_count", cycle_count, 10);
      drive(0, 0, 0, 0, 1, 1); #1;
      check("stall_pc_en", 32'(pc_en), 0);
      check("stall_ifid_en", 32'(ifid_en), 0);
      check("stall_idex_flush", 32'(idex_flush), 1);
      check("stall_ifid_flush", 32'(ifid_flush), 0);
      tick();
      drive(0, 0, 0, 0, 0, 1); #1;
      check("flush_ifid_flush", 32'(ifid_flush), 1);
      check("flush_pc_en", 32'(pc_en), 1);
      tick();
      cycles(2);
      drive(0, 0, 0, 1, 0, 0); #1;
      check("halt_pc_en", 32'(pc_en), 0);
      check("halt_ifid_flush", 32'(ifid_flush), 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("drain_state", 32'(state), 3);
         drive(1, 1, 0, 0, 1, 1);
         tick();
      end
      check("halted_state", 32'(state), 4);
      check("halt_count", cycle_count, 19);
      drive(1, 0, 0, 0, 0, 0); tick();
      check("halted_sticky", 32'(state), 4);
      check("halted_count_hold", cycle_count, 19);

      // Two single steps separated by idle cycles.
      apply_reset();
      se_seen = 0;
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 0, 0, 0, 0); tick();
         check("step_state", 32'(state), 2);
         cycles(1);
         check("step_return", 32'(state), 0);
         cycles(5);
      end
      check("step_stage_cycles", 32'(se_seen), 2);
      check("step_count", cycle_count, 2);

      // Run beats step; stop forces a full drain.
      apply_reset();
      drive(1, 1, 0, 0, 0, 0); tick();
      check("run_wins", 32'(state), 1);
      drive(0, 0, 1, 0, 0, 0); tick();
      check("stop_drain", 32'(state), 3);
      cycles(3);
      check("stop_drain_last", 32'(state), 3);
      cycles(1);
      check("stop_halted", 32'(state), 4);

      // Asynchronous reset while draining.
      apply_reset();
      drive(1, 0, 0, 0, 0, 0); tick();
      cycles(3);
      drive(0, 0, 1, 0, 0, 0); tick();
      cycles(1);
      check("pre_rst_state", 32'(state), 3);
      check("pre_rst_count", cycle_count, 5);
      apply_reset();
      check("post_rst_state", 32'(state), 0);
      check("post_rst_count", cycle_count, 0);
      check("post_rst_busy", 32'(busy), 0);
      cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
